// File: rtl/jtframe_dpram_fifo_if.sv
// Producer/consumer handshake bundle for jtframe_dpram_fifo.
// master = the side that writes and pops; slave = the FIFO itself.
interface jtframe_dpram_fifo_if #(
    parameter int dw = 8
);
    logic [dw-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [dw-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/jtframe_dpram_fifo.sv
// FIFO controller on top of an external dual-port RAM with a
// registered read port; rd_data comes straight from the RAM output.
module jtframe_dpram_fifo #(
    parameter int dw = 8,
    parameter int aw = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    jtframe_dpram_fifo_if.slave bus,
    output logic [aw:0]   level,
    output logic          full,
    output logic          empty,
    output logic [aw-1:0] ram_addr0,
    output logic [dw-1:0] ram_data0,
    output logic          ram_we0,
    output logic [aw-1:0] ram_addr1,
    input  logic [dw-1:0] ram_q1
);

    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr;
    logic          rd_valid;
    logic          push;
    logic          pop;

    // level never exceeds 2**aw, so its top bit alone marks "full"
    assign full  = level[aw];
    assign empty = (level == '0);

    assign bus.wr_ready = ~full;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = ram_q1;

    // rst_n gates the write strobe so nothing reaches the RAM in reset
    assign push = bus.wr_valid & ~full & ~flush & rst_n;
    assign pop  = rd_valid & bus.rd_ready;

    assign ram_we0   = push;
    assign ram_addr0 = wr_ptr;
    assign ram_data0 = bus.wr_data;

    // Look one entry ahead on a pop so the RAM output tracks the new head
    assign ram_addr1 = pop ? rd_ptr + 1'b1 : rd_ptr;

    // Pointer, occupancy and read-valid state; the address presented at
    // this edge is valid next cycle only if it holds an entry written at
    // an earlier edge (level minus this pop), avoiding read-old-data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            rd_valid <= level > {{aw{1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_jtframe_dpram_fifo.sv
// Self-checking bench for jtframe_dpram_fifo (dw=8, aw=4) with a
// behavioural registered-read RAM and a queue-based scoreboard.
module tb_jtframe_dpram_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic [AW-1:0] ram_addr0;
    logic [DW-1:0] ram_data0;
    logic          ram_we0;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_q1;
    logic [DW-1:0] mem [DEPTH];

    jtframe_dpram_fifo_if #(.dw(DW)) bus ();

    jtframe_dpram_fifo #(.dw(DW), .aw(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .ram_addr0 (ram_addr0),
        .ram_data0 (ram_data0),
        .ram_we0   (ram_we0),
        .ram_addr1 (ram_addr1),
        .ram_q1    (ram_q1)
    );

    always #5 clk = ~clk;

    // Dual-port RAM: registered read, old data on same-address access
    always @(posedge clk) begin
        if (ram_we0) mem[ram_addr0] <= ram_data0;
        ram_q1 <= mem[ram_addr1];
    end

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  q [$];
    int          mlevel = 0;
    bit          mrv = 0;
    int          mwp = 0;

    function automatic bit exp_push();
        return bus.wr_valid && (mlevel < DEPTH) && !flush && rst_n;
    endfunction

    task automatic drive(input bit wv, input logic [7:0] wd,
                         input bit rr, input bit fl);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        flush        = fl;
        #1;
    endtask

    task automatic tick();
        bit pu;
        bit po;
        pu = exp_push();
        po = mrv && bus.rd_ready;
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                q.delete();
                mlevel = 0;
                mrv    = 0;
                mwp    = 0;
            end else begin
                mrv = (mlevel - int'(po)) != 0;
                if (po) void'(q.pop_front());
                if (pu) begin
                    q.push_back(bus.wr_data);
                    mwp = (mwp + 1) % DEPTH;
                end
                mlevel = mlevel + int'(pu) - int'(po);
            end
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        mlevel = 0;
        mrv    = 0;
        mwp    = 0;
    endtask

    task automatic drain();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40 && (q.size() != 0 || mrv); i++) tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
    endtask

    // Scoreboard: every cycle the DUT is compared against the model
    always @(negedge clk) begin
        tests++;
        if (level !== (AW+1)'(mlevel) || wr_ready_chk() ||
            full !== (mlevel == DEPTH) || empty !== (mlevel == 0)) begin
            fails++;
            $display("FAIL sb_status: level=%0d full=%b empty=%b wr_ready=%b, need level=%0d",
                     level, full, empty, bus.wr_ready, mlevel);
        end
        tests++;
        if (bus.rd_valid !== mrv) begin
            fails++;
            $display("FAIL sb_rd_valid: got %b need %b", bus.rd_valid, mrv);
        end
        tests++;
        if (ram_we0 !== exp_push()) begin
            fails++;
            $display("FAIL sb_we0: got %b need %b", ram_we0, exp_push());
        end
        if (exp_push() && ram_we0) begin
            tests++;
            if (ram_addr0 !== AW'(mwp) || ram_data0 !== bus.wr_data) begin
                fails++;
                $display("FAIL sb_wr_port: addr=%0d data=%h need addr=%0d data=%h",
                         ram_addr0, ram_data0, mwp, bus.wr_data);
            end
        end
        if (mrv && bus.rd_valid && q.size() != 0) begin
            tests++;
            if (bus.rd_data !== q[0]) begin
                fails++;
                $display("FAIL sb_rd_data: got %h need %h", bus.rd_data, q[0]);
            end
        end
    end

    function automatic bit wr_ready_chk();
        return bus.wr_ready !== (mlevel != DEPTH);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        tests++;
        if (ram_we0 !== 1'b0 || bus.wr_ready !== 1'b1 || level !== '0 ||
            empty !== 1'b1 || full !== 1'b0 || bus.rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals: we0=%b rdy=%b lvl=%0d empty=%b full=%b rv=%b",
                     ram_we0, bus.wr_ready, level, empty, full, bus.rd_valid);
        end
        tick();
        tick();
        @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_single();
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        tests++;
        if (ram_we0 !== 1'b1 || ram_addr0 !== 4'd0) begin
            fails++;
            $display("FAIL single_c0: we0=%b addr0=%0d need 1/0", ram_we0, ram_addr0);
        end
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tests++;
        if (bus.rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_c1: rd_valid=%b need 0", bus.rd_valid);
        end
        tick();
        tests++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5A) begin
            fails++;
            $display("FAIL single_c2: rv=%b data=%h need 1/5a", bus.rd_valid, bus.rd_data);
        end
        tick();
        tests++;
        if (level !== '0) begin
            fails++;
            $display("FAIL single_lvl: level=%0d need 0", level);
        end
        tick();
    endtask

    task automatic test_fill_and_full_pop();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        tests++;
        if (full !== 1'b1 || level !== 5'd16 || bus.wr_ready !== 1'b0 || ram_we0 !== 1'b0) begin
            fails++;
            $display("FAIL fill_full: full=%b lvl=%0d rdy=%b we0=%b need 1/16/0/0",
                     full, level, bus.wr_ready, ram_we0);
        end
        tick();
        tests++;
        if (level !== 5'd16) begin
            fails++;
            $display("FAIL fill_17th: level=%0d need 16", level);
        end
        drive(1'b1, 8'hA0, 1'b1, 1'b0);
        tests++;
        if (ram_we0 !== 1'b0 || bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h00) begin
            fails++;
            $display("FAIL full_both: we0=%b rv=%b data=%h need 0/1/00",
                     ram_we0, bus.rd_valid, bus.rd_data);
        end
        tick();
        drive(1'b1, 8'hA0, 1'b0, 1'b0);
        tests++;
        if (level !== 5'd15 || ram_we0 !== 1'b1) begin
            fails++;
            $display("FAIL full_after: level=%0d we0=%b need 15/1", level, ram_we0);
        end
        tick();
        drain();
        tests++;
        if (empty !== 1'b1) begin
            fails++;
            $display("FAIL fill_drain: empty=%b need 1", empty);
        end
    endtask

    task automatic test_stream();
        int zeros;
        int gaps;
        bit seen;
        zeros = 0;
        gaps  = 0;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            if (ram_we0 && ram_addr0 == 4'd0) zeros++;
            if (seen && !bus.rd_valid) gaps++;
            if (bus.rd_valid) seen = 1;
            tick();
        end
        tests++;
        if (!seen || gaps != 0 || zeros < 2) begin
            fails++;
            $display("FAIL stream: seen=%b gaps=%0d addr0_zero=%0d need 1/0/>=2",
                     seen, gaps, zeros);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a1;
        int bad;
        int ok;
        bad = 0;
        ok  = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        a1 = ram_addr1;
        for (int i = 0; i < 5; i++) begin
            drive(i < 2, 8'(8'h33 + i), 1'b0, 1'b0);
            if (!bus.rd_valid || bus.rd_data !== 8'h30 || ram_addr1 !== a1) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_stable: %0d unstable cycles, need 0", bad);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            if (bus.rd_valid && bus.rd_data === 8'(8'h30 + i)) ok++;
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tests++;
        if (ok != 5 || empty !== 1'b1) begin
            fails++;
            $display("FAIL bp_pops: %0d in-order pops empty=%b, need 5/1", ok, empty);
        end
        tick();
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hF0, 1'b1, 1'b1);
        tests++;
        if (ram_we0 !== 1'b0) begin
            fails++;
            $display("FAIL flush_we: we0=%b need 0", ram_we0);
        end
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tests++;
        if (level !== '0 || bus.rd_valid !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL flush_state: lvl=%0d rv=%b empty=%b need 0/0/1",
                     level, bus.rd_valid, empty);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (level !== '0 || bus.rd_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 ||
            bus.wr_ready !== 1'b1 || ram_we0 !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: lvl=%0d rv=%b empty=%b full=%b rdy=%b we0=%b",
                     level, bus.rd_valid, empty, full, bus.wr_ready, ram_we0);
        end
        tick();
        @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 8'h99, 1'b1, 1'b0);
        tests++;
        if (ram_we0 !== 1'b1 || ram_addr0 !== 4'd0) begin
            fails++;
            $display("FAIL rst_first_wr: we0=%b addr0=%0d need 1/0", ram_we0, ram_addr0);
        end
        tick();
        drain();
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_and_full_pop();
        test_stream();
        test_backpressure();
        test_flush_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jtframe_dpram_fifo.md
JTFRAME_DPRAM_FIFO -- requirements
Module: jtframe_dpram_fifo

Interface
REQ-001 Parameter dw, default 8: data width in bits, passed unchanged to the attached dual-port RAM.
REQ-002 Parameter aw, default 10: RAM address width; FIFO capacity SHALL be 2**aw entries.
REQ-003 clk  input  1  single clock for all logic and for both attached RAM ports.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous clear, active high.
REQ-006 wr_data  input  dw  data to be written.
REQ-007 wr_valid  input  1  the producer offers wr_data.
REQ-008 wr_ready  output  1  the block can accept; the write takes effect when wr_valid and wr_ready are both high at a rising edge.
REQ-009 rd_data  output  dw  head-of-queue data; driven directly from ram_q1.
REQ-010 rd_valid  output  1  rd_data holds the oldest unread entry.
REQ-011 rd_ready  input  1  the consumer takes the entry; the pop takes effect when rd_valid and rd_ready are both high at a rising edge.
REQ-012 level  output  aw+1  number of entries accepted and not yet popped.
REQ-013 full  output  1  level equals 2**aw; empty  output  1  level equals 0.
REQ-014 ram_addr0  output  aw; ram_data0  output  dw; ram_we0  output  1: RAM port 0, write-only, to be connected with cen0 tied to 1.
REQ-015 ram_addr1  output  aw; ram_q1  input  dw: RAM port 1, read-only, we1 tied to 0, cen1 tied to 1; ram_q1 is registered with 1-cycle latency from ram_addr1.

Function
REQ-016 ram_we0 SHALL be combinationally equal to wr_valid AND wr_ready AND NOT flush; ram_addr0 SHALL equal the write pointer; ram_data0 SHALL equal wr_data.
REQ-017 The write pointer SHALL increment by 1 modulo 2**aw on each accepted write; the read pointer SHALL increment by 1 modulo 2**aw on each pop.
REQ-018 wr_ready SHALL be combinationally equal to NOT full; a pop in the same cycle SHALL NOT make wr_ready high while full.
REQ-019 level SHALL update as follows: +1 on a write without a pop; -1 on a pop without a write; unchanged when both occur in the same cycle. It SHALL never exceed 2**aw and never go below 0.
REQ-020 ram_addr1 SHALL equal read pointer + 1 (mod 2**aw) during a cycle in which a pop occurs, and the read pointer otherwise, so that back-to-back pops sustain one entry per cycle.
REQ-021 An entry written at rising edge E SHALL NOT be presented as rd_data until after the next rising edge. This avoids the RAM's read-old-data behaviour on same-address access.
REQ-022 Latency: a write accepted in cycle N into an empty FIFO SHALL produce rd_valid high in cycle N+2, with rd_data equal to that entry.
REQ-023 rd_valid SHALL be registered. It SHALL be high in a cycle exactly when the address presented at the previous edge held an entry committed to RAM before that edge and not yet popped.
REQ-024 While rd_valid is high and rd_ready is low, ram_addr1, rd_data and rd_valid SHALL remain stable, including across concurrent writes.
REQ-025 Wrap-around: the pointers SHALL wrap from 2**aw-1 to 0 with no gap and no reordering.
REQ-026 When full, with a simultaneous write attempt and pop: the pop occurs, the write is refused, and level becomes 2**aw-1.
REQ-027 When empty, a write SHALL be accepted; rd_valid SHALL stay low in the cycle of the write and in the cycle that follows it.
REQ-028 Flush: at the rising edge where flush is high, both pointers, level and rd_valid SHALL return to their reset values; a write offered in that cycle SHALL be discarded, and a pop in that cycle SHALL have no further effect.
REQ-029 While flush is high, wr_ready MAY stay high, but no RAM write SHALL occur.

Reset
REQ-030 While rst_n is low, regardless of clk: write pointer = 0, read pointer = 0, level = 0, rd_valid = 0, full = 0, empty = 1, wr_ready = 1, ram_we0 = 0.
REQ-031 Reset asserted mid-operation SHALL discard all content. After rst_n is released, the first write SHALL go to address 0.
REQ-032 RAM contents SHALL NOT be cleared by reset; correctness SHALL NOT depend on them.

Verification
REQ-033 Single entry, dw=8, aw=4, rd_ready=1: write 0x5A in cycle 0 -> ram_we0=1 with ram_addr0=0 in cycle 0; rd_valid=1 with rd_data=0x5A in cycle 2; level returns to 0 after the pop.
REQ-034 Fill: 16 writes of 0..15 with rd_ready=0 -> full=1, level=16, wr_ready=0; a 17th write is refused, ram_we0 stays 0 and level stays 16.
REQ-035 Streaming wrap: wr_valid=1 and rd_ready=1 continuously for 40 cycles with an incrementing data pattern -> the output sequence equals the input sequence with no gaps after the first rd_valid, and the pointers pass through address 0 twice.
REQ-036 Backpressure: with 3 entries stored, hold rd_ready low for 5 cycles while 2 more writes occur -> rd_data stays equal to entry 0 and ram_addr1 stays constant; then 5 pops return entries 0..4 in order.
REQ-037 Full with simultaneous events: with the FIFO full, assert wr_valid and rd_ready together -> exactly one pop, no write, level=15; in the next cycle the write is accepted.
REQ-038 Flush and reset: with 6 entries stored, pulse flush together with a write -> the next cycle shows level=0, rd_valid=0, empty=1 and no RAM write. Repeat the setup with rst_n pulsed low asynchronously between edges -> outputs take their reset values immediately.
